uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver paired with `uart_tx` and driven by the shared `baudrate_generator` 16x-oversampling tick. It recovers LSB-first frames (start bit, NB_DATA data bits, NB_STOP stop bits, no parity) from an asynchronous serial line. For each good frame it presents the byte with a one-cycle valid strobe. Bad stop bits are flagged as framing errors.

## Interface
- NB_DATA, 8, data bits per frame
- NB_STOP, 1, stop bits per frame (1 or 2)
- NB_TICK_COUNTER, 4, width of oversample counter (16 ticks/bit)
- NB_DATA_COUNTER, 3, width of data-bit counter ($clog2(NB_DATA))
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset (low = reset)
- i_tick  in  1  one-cycle pulse at 16x baud rate from baudrate_generator
- i_rx  in  1  asynchronous serial line, idle high
- o_data  out  NB_DATA  last correctly received byte, held until next valid
- o_data_valid  out  1  one-cycle pulse: o_data updated with new byte
- o_frame_error  out  1  one-cycle pulse: stop bit sampled low
- o_busy  out  1  high whenever state != IDLE

## Operation
- i_rx passes through a 2-flop synchronizer (both flops reset to 1); all decisions use synchronized rx.
- Tick counter counts i_tick pulses only; cycles without i_tick hold all counters.
- States IDLE, START, DATA, STOP:
  - IDLE: rx==0 -> START, clear tick counter.
  - START: on tick at count 7 (mid start bit): rx==0 -> DATA, clear tick and bit counters; rx==1 -> IDLE (glitch rejected, no output pulse).
  - DATA: on tick at count 15, sample rx and shift it into the MSB of the shift register (shift right, LSB-first). Increment bit counter and clear tick counter. After bit NB_DATA-1 -> STOP.
  - STOP: on tick at count 15 sample rx. Repeat NB_STOP times. A zero on any stop sample marks an error.
  - After the final stop sample, go to IDLE:
    - no error: o_data <= shift register and o_data_valid pulses.
    - error: o_frame_error pulses and o_data is unchanged.
- A sustained break (line held low) produces a frame error, then immediately re-enters START. It repeats one frame error per frame time until the line returns high.
- No FIFO: a consumer must capture o_data within one frame time.

## Timing
- Reset values: o_data=0, o_data_valid=0, o_frame_error=0, o_busy=0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts at once. No pulse is generated and the partial byte is discarded.
- Synchronizer latency: 2 cycles from i_rx edge to FSM visibility.
- All samples sit mid-bit: 8 ticks after the detected start edge, then every 16 ticks.
- o_data_valid / o_frame_error rise on the clock edge that processes the final stop-bit tick. They are high for exactly one i_clock cycle. They are never high together.
- o_busy rises the cycle after the FSM leaves IDLE and falls with the valid/error pulse.
- Back-to-back frames (a start bit immediately after a stop bit) are received without loss. The FSM is back in IDLE about 8 ticks before the stop bit ends.
- Default system (100 MHz, 9600 baud, TICK_RATE=651): one bit = 16 ticks ≈ 104.2 us.

## Test plan
- Single frame 0x55, NB_STOP=1, driven with 104.2 us bit time -> one o_data_valid pulse, o_data=0x55, o_frame_error never high.
- Loopback: uart_tx sends 0xA5 then 0x3C back-to-back into i_rx -> two valid pulses with o_data 0xA5 then 0x3C, none dropped.
- Start glitch: i_rx low for 3 ticks (~19.5 us) then high -> FSM returns to IDLE, no valid/error pulse, o_busy drops within 8 ticks.
- Framing error: frame 0xF0 with stop bit driven low -> o_frame_error pulses once, o_data keeps previous value, o_data_valid stays 0.
- Reset mid-frame: drive i_reset low during data bit 4 of 0x81, release, then send 0x81 cleanly -> no pulse from aborted frame; exactly one valid with o_data=0x81.
- NB_STOP=2: frame 0x7E with second stop bit low -> o_frame_error pulse. Same frame with both stops high -> valid with 0x7E.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, LSB-first frames with NB_DATA data bits and
// NB_STOP stop bits; one-cycle valid / framing-error strobes per frame.
module uart_rx #(
  parameter int NB_DATA         = 8,
  parameter int NB_STOP         = 1,
  parameter int NB_TICK_COUNTER = 4,
  parameter int NB_DATA_COUNTER = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_data_valid,
  output logic               o_frame_error,
  output logic               o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [NB_TICK_COUNTER-1:0] TICK_MID  = {1'b0, {(NB_TICK_COUNTER-1){1'b1}}};
  localparam logic [NB_TICK_COUNTER-1:0] TICK_LAST = '1;
  localparam logic [NB_DATA_COUNTER-1:0] LAST_BIT  = NB_DATA_COUNTER'(NB_DATA - 1);
  localparam logic [NB_DATA_COUNTER-1:0] LAST_STOP = NB_DATA_COUNTER'(NB_STOP - 1);

  state_t                     r_state;
  state_t                     w_next_state;
  logic                       r_rx_meta;
  logic                       r_rx_sync;
  logic [NB_TICK_COUNTER-1:0] r_tick_cnt;
  logic [NB_DATA_COUNTER-1:0] r_bit_cnt;
  logic [NB_DATA-1:0]         r_shift;
  logic [NB_DATA-1:0]         r_data;
  logic                       r_stop_err;
  logic                       r_data_valid;
  logic                       r_frame_error;

  logic w_tick_mid;
  logic w_tick_end;
  logic w_frame_done;
  logic w_frame_bad;

  assign w_tick_mid = i_tick && (r_tick_cnt == TICK_MID);
  assign w_tick_end = i_tick && (r_tick_cnt == TICK_LAST);

  // Synchronizer flops reset to the idle line level so reset release never
  // looks like a start edge.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns w_next_state; no latch inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_sync) w_next_state = S_START;
      S_START: if (w_tick_mid) w_next_state = r_rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick_end && r_bit_cnt == LAST_BIT) w_next_state = S_STOP;
      S_STOP:  if (w_tick_end && r_bit_cnt == LAST_STOP) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output / frame-result decode
  always_comb begin
    o_busy       = (r_state != S_IDLE);
    w_frame_done = (r_state == S_STOP) && w_tick_end && (r_bit_cnt == LAST_STOP);
    w_frame_bad  = r_stop_err || !r_rx_sync;
  end

  // Datapath: counters, shift register, result strobes
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_stop_err    <= 1'b0;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      r_data_valid  <= w_frame_done && !w_frame_bad;
      r_frame_error <= w_frame_done &&  w_frame_bad;
      if (w_frame_done && !w_frame_bad) r_data <= r_shift;

      case (r_state)
        S_IDLE: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
          r_stop_err <= 1'b0;
        end
        S_START: if (i_tick) begin
          if (w_tick_mid) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        S_DATA: if (i_tick) begin
          if (w_tick_end) begin
            r_tick_cnt <= '0;
            r_shift    <= {r_rx_sync, r_shift[NB_DATA-1:1]};
            // Bit counter restarts here and doubles as the stop-bit counter.
            r_bit_cnt  <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        S_STOP: if (i_tick) begin
          if (w_tick_end) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (!r_rx_sync) r_stop_err <= 1'b1;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        default: r_tick_cnt <= '0;
      endcase
    end
  end

  assign o_data        = r_data;
  assign o_data_valid  = r_data_valid;
  assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one NB_STOP=1 and one NB_STOP=2 instance,
// directed and random frames checked against an event-level frame model.
module tb_uart_rx;

  localparam int TICK_DIV = 4;                 // clock cycles per oversample tick
  localparam int BIT_CYC  = 16 * TICK_DIV;     // clock cycles per serial bit

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx1 = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] data1, data2;
  logic       dv1, dv2, fe1, fe2, busy1, busy2;

  int n_cmp = 0;
  int n_bad = 0;

  ev_t obs1[$], obs2[$], exp1[$], exp2[$];
  logic [7:0] last_good1 = 8'h00;
  logic [7:0] last_good2 = 8'h00;
  int both_hi = 0;
  int wide = 0;
  logic pdv1 = 0, pfe1 = 0, pdv2 = 0, pfe2 = 0;

  uart_rx #(.NB_DATA(8), .NB_STOP(1), .NB_TICK_COUNTER(4), .NB_DATA_COUNTER(3)) u_dut1 (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx1),
    .o_data(data1), .o_data_valid(dv1), .o_frame_error(fe1), .o_busy(busy1)
  );

  uart_rx #(.NB_DATA(8), .NB_STOP(2), .NB_TICK_COUNTER(4), .NB_DATA_COUNTER(3)) u_dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx2),
    .o_data(data2), .o_data_valid(dv2), .o_frame_error(fe2), .o_busy(busy2)
  );

  always #5 clk = ~clk;

  // Free-running 16x tick, driven away from the active edge.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      tick = (cnt == TICK_DIV - 1);
      cnt  = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
    end
  end

  // Pulse monitor: records every strobe with the o_data seen alongside it.
  always @(negedge clk) begin
    if (dv1 || fe1) obs1.push_back('{err: fe1, data: data1});
    if (dv2 || fe2) obs2.push_back('{err: fe2, data: data2});
    if ((dv1 && fe1) || (dv2 && fe2)) both_hi++;
    if ((dv1 && pdv1) || (fe1 && pfe1) || (dv2 && pdv2) || (fe2 && pfe2)) wide++;
    pdv1 = dv1; pfe1 = fe1; pdv2 = dv2; pfe2 = fe2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic v, input int cyc);
    if (sel == 1) rx1 = v;
    else          rx2 = v;
    wait_cyc(cyc);
  endtask

  // Model: a frame is good iff every stop bit is high. A good frame yields a
  // valid strobe carrying the byte; a bad one yields an error strobe while
  // o_data keeps the last good byte. A low stop bit is held low across its
  // mid-point only, so the trailing edge cannot be mistaken for a new start.
  task automatic send_frame(input int sel, input logic [7:0] b, input int nstop,
                            input logic [1:0] stop_ok);
    ev_t e;
    logic good = 1'b1;
    drive(sel, 1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive(sel, b[i], BIT_CYC);
    for (int s = 0; s < nstop; s++) begin
      if (stop_ok[s]) drive(sel, 1'b1, BIT_CYC);
      else begin
        good = 1'b0;
        drive(sel, 1'b0, 11 * TICK_DIV);
        drive(sel, 1'b1, 5 * TICK_DIV);
      end
    end
    if (sel == 1) begin
      e = '{err: !good, data: good ? b : last_good1};
      if (good) last_good1 = b;
      exp1.push_back(e);
    end else begin
      e = '{err: !good, data: good ? b : last_good2};
      if (good) last_good2 = b;
      exp2.push_back(e);
    end
  endtask

  task automatic check_events(input int sel, input string tag);
    ev_t o[$];
    ev_t e[$];
    if (sel == 1) begin o = obs1; e = exp1; obs1 = {}; exp1 = {}; end
    else          begin o = obs2; e = exp2; obs2 = {}; exp2 = {}; end
    check({tag, "_count"}, o.size(), e.size());
    for (int i = 0; i < e.size() && i < o.size(); i++) begin
      check($sformatf("%s_err%0d", tag, i), o[i].err, e[i].err);
      check($sformatf("%s_data%0d", tag, i), o[i].data, e[i].data);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [1:0] st;

    // Reset state
    wait_cyc(3);
    check("rst_data1", data1, 8'h00);
    check("rst_valid1", dv1, 1'b0);
    check("rst_ferr1", fe1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    rst_n = 1'b1;
    wait_cyc(BIT_CYC);

    // Single frame 0x55, with busy observed mid-frame
    fork
      send_frame(1, 8'h55, 1, 2'b11);
      begin wait_cyc(4 * BIT_CYC); check("busy_midframe", busy1, 1'b1); end
    join
    wait_cyc(BIT_CYC);
    check_events(1, "f55");
    check("idle_after_f55", busy1, 1'b0);

    // Back-to-back A5, 3C, then a burst of random back-to-back frames
    send_frame(1, 8'hA5, 1, 2'b11);
    send_frame(1, 8'h3C, 1, 2'b11);
    for (int k = 0; k < 8; k++) send_frame(1, 8'($urandom), 1, 2'b11);
    wait_cyc(BIT_CYC);
    check_events(1, "b2b");
    check("held_data", data1, last_good1);

    // Start glitch: 3 ticks low, then high
    drive(1, 1'b0, 3 * TICK_DIV);
    check("glitch_busy_hi", busy1, 1'b1);
    drive(1, 1'b1, 8 * TICK_DIV + 4);
    check("glitch_busy_lo", busy1, 1'b0);
    wait_cyc(BIT_CYC);
    check_events(1, "glitch");

    // Framing error on 0xF0 keeps the previous byte
    send_frame(1, 8'hF0, 1, 2'b10);
    wait_cyc(BIT_CYC);
    check_events(1, "ferr");
    check("ferr_hold", data1, last_good1);

    // Reset during data bit 4 of 0x81
    drive(1, 1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) drive(1, 1'(8'h81 >> i), BIT_CYC);
    drive(1, 1'b0, BIT_CYC / 2);
    rst_n = 1'b0;
    rx1 = 1'b1;
    #1;
    check("rst_mid_busy", busy1, 1'b0);
    check("rst_mid_data", data1, 8'h00);
    last_good1 = 8'h00;
    last_good2 = 8'h00;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(12 * BIT_CYC);
    check_events(1, "aborted");
    send_frame(1, 8'h81, 1, 2'b11);
    wait_cyc(BIT_CYC);
    check_events(1, "f81");

    // Break: line low 368 ticks. Stop samples land 152 ticks apart, so two
    // errors; the third frame samples bits 0-2 low and 3-7 high -> 0xF8.
    exp1.push_back('{err: 1'b1, data: last_good1});
    exp1.push_back('{err: 1'b1, data: last_good1});
    exp1.push_back('{err: 1'b0, data: 8'hF8});
    last_good1 = 8'hF8;
    drive(1, 1'b0, 368 * TICK_DIV);
    drive(1, 1'b1, 12 * BIT_CYC);
    check_events(1, "break");

    // NB_STOP=2 instance: second stop low, then clean, then random patterns
    send_frame(2, 8'h7E, 2, 2'b01);
    send_frame(2, 8'h7E, 2, 2'b11);
    for (int k = 0; k < 6; k++) begin
      b  = 8'($urandom);
      st = 2'($urandom_range(3, 0));
      send_frame(2, b, 2, st);
      wait_cyc(BIT_CYC);
    end
    wait_cyc(BIT_CYC);
    check_events(2, "stop2");
    check("stop2_hold", data2, last_good2);

    check("pulse_overlap", both_hi, 0);
    check("pulse_width", wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
